// File: rtl/conf_loader_pkg.sv
// conf_loader shared types and constants.
// Neuron chain geometry and loader FSM states.
package conf_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int NEURON_BITS   = 17;
  localparam int NEURONS       = 25;
  localparam int CHAIN_LEN_DEF = NEURON_BITS * NEURONS;

endpackage

// File: rtl/conf_rb_deser.sv
// conf_rb_deser: 8-bit serial-to-parallel readback assembler.
// Flush emits a partial byte left-aligned, zero-padded.
module conf_rb_deser (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic       sample_bit,
  input  logic       flush,
  output logic [7:0] rb_data,
  output logic       rb_valid
);

  logic [7:0] sr_q, sr_d, sr_n;
  logic [7:0] data_q, data_d;
  logic [3:0] cnt_q, cnt_d, cnt_n;
  logic       valid_q, valid_d;

  // Shift in a sample, emit on 8 bits or on flush of a partial byte.
  always_comb begin
    sr_n    = sample_en ? {sr_q[6:0], sample_bit} : sr_q;
    cnt_n   = cnt_q + {3'd0, sample_en};
    sr_d    = sr_n;
    cnt_d   = cnt_n;
    data_d  = data_q;
    valid_d = 1'b0;
    if (cnt_n == 4'd8) begin
      valid_d = 1'b1;
      data_d  = sr_n;
      sr_d    = '0;
      cnt_d   = '0;
    end else if (flush && cnt_n != 4'd0) begin
      valid_d = 1'b1;
      data_d  = sr_n << (4'd8 - cnt_n);
      sr_d    = '0;
      cnt_d   = '0;
    end
  end

  // Readback state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rb_data  = data_q;
  assign rb_valid = valid_q;

endmodule

// File: rtl/conf_loader.sv
// conf_loader: host byte stream to neuron config chain,
// with serial readback of the chain tail.
module conf_loader
  import conf_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int NBYTES    = (CHAIN_LEN + 7) / 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       conf_en,
  output logic       bs_in,
  input  logic       bs_out,
  output logic       nn_reset,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  output logic       busy,
  output logic       done
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int YW = $clog2(NBYTES + 1);
  localparam int REM = CHAIN_LEN % 8;
  localparam logic [3:0] LAST_BITS =
    (REM == 0) ? 4'd8 : 4'(REM);
  localparam logic [BW-1:0] BIT_INIT  = BW'(CHAIN_LEN);
  localparam logic [YW-1:0] BYTE_INIT = YW'(NBYTES);

  state_e          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [YW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]      buf_q, buf_d;
  logic [3:0]      buf_cnt_q, buf_cnt_d;
  logic            conf_en_q, conf_en_d;
  logic            bs_in_q, bs_in_d;
  logic            nn_reset_q, nn_reset_d;
  logic            done_q, done_d;
  logic            take, shift_en;

  assign in_ready = (state_q == SHIFT) &&
                    (byte_cnt_q != '0) &&
                    (buf_cnt_q <= 4'd1);
  assign take     = in_valid & in_ready;
  assign shift_en = (state_q == SHIFT) &&
                    (buf_cnt_q != 4'd0) &&
                    (bit_cnt_q != '0);

  // Frame FSM: accept bytes, shift chain bits, then finish.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    buf_cnt_d  = buf_cnt_q;
    conf_en_d  = 1'b0;
    bs_in_d    = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SHIFT;
          bit_cnt_d  = BIT_INIT;
          byte_cnt_d = BYTE_INIT;
          buf_d      = '0;
          buf_cnt_d  = '0;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          conf_en_d = 1'b1;
          bs_in_d   = buf_q[7];
          buf_d     = {buf_q[6:0], 1'b0};
          buf_cnt_d = buf_cnt_q - 4'd1;
          bit_cnt_d = bit_cnt_q - BW'(1);
          if (bit_cnt_q == BW'(1)) state_d = FINISH;
        end
        if (take) begin
          buf_d      = in_data;
          buf_cnt_d  = (byte_cnt_q == YW'(1)) ?
                       LAST_BITS : 4'd8;
          byte_cnt_d = byte_cnt_q - YW'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    nn_reset_d = (state_d != IDLE) || (state_q == FINISH);
  end

  // Loader state registers; nn_reset held high in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      buf_cnt_q  <= '0;
      conf_en_q  <= 1'b0;
      bs_in_q    <= 1'b0;
      nn_reset_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      buf_cnt_q  <= buf_cnt_d;
      conf_en_q  <= conf_en_d;
      bs_in_q    <= bs_in_d;
      nn_reset_q <= nn_reset_d;
      done_q     <= done_d;
    end
  end

  conf_rb_deser u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (conf_en_q),
    .sample_bit (bs_out),
    .flush      (state_q == FINISH),
    .rb_data    (rb_data),
    .rb_valid   (rb_valid)
  );

  assign conf_en  = conf_en_q;
  assign bs_in    = bs_in_q;
  assign nn_reset = nn_reset_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_conf_loader.sv
// tb_conf_loader: directed + random frames on a 10-bit
// and a default-length loader, each closing a delay chain.
module tb_conf_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, in_valid, sel, ld;
  logic [7:0]   in_data;
  logic [424:0] pre;
  logic [9:0]   chain_a;
  logic [424:0] chain_b;

  logic       a_in_ready, a_conf_en, a_bs_in, a_nn_reset;
  logic       a_rb_valid, a_busy, a_done;
  logic [7:0] a_rb_data;
  logic       b_in_ready, b_conf_en, b_bs_in, b_nn_reset;
  logic       b_rb_valid, b_busy, b_done;
  logic [7:0] b_rb_data;

  conf_loader #(.CHAIN_LEN(10)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start & ~sel),
    .in_data  (in_data),
    .in_valid (in_valid & ~sel),
    .in_ready (a_in_ready),
    .conf_en  (a_conf_en),
    .bs_in    (a_bs_in),
    .bs_out   (chain_a[9]),
    .nn_reset (a_nn_reset),
    .rb_data  (a_rb_data),
    .rb_valid (a_rb_valid),
    .busy     (a_busy),
    .done     (a_done)
  );

  conf_loader u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start & sel),
    .in_data  (in_data),
    .in_valid (in_valid & sel),
    .in_ready (b_in_ready),
    .conf_en  (b_conf_en),
    .bs_in    (b_bs_in),
    .bs_out   (chain_b[424]),
    .nn_reset (b_nn_reset),
    .rb_data  (b_rb_data),
    .rb_valid (b_rb_valid),
    .busy     (b_busy),
    .done     (b_done)
  );

  // Neuron chain stand-in: delay line advanced by conf_en.
  always @(posedge clk) begin
    if (ld) begin
      chain_a <= pre[9:0];
      chain_b <= pre;
    end else begin
      if (a_conf_en) chain_a <= {chain_a[8:0], a_bs_in};
      if (b_conf_en) chain_b <= {chain_b[423:0], b_bs_in};
    end
  end

  wire       m_in_ready = sel ? b_in_ready : a_in_ready;
  wire       m_conf_en  = sel ? b_conf_en  : a_conf_en;
  wire       m_bs_in    = sel ? b_bs_in    : a_bs_in;
  wire       m_nn_reset = sel ? b_nn_reset : a_nn_reset;
  wire       m_rb_valid = sel ? b_rb_valid : a_rb_valid;
  wire       m_busy     = sel ? b_busy     : a_busy;
  wire       m_done     = sel ? b_done     : a_done;
  wire [7:0] m_rb_data  = sel ? b_rb_data  : a_rb_data;

  int checks = 0;
  int fails  = 0;

  logic [7:0] tx [64];
  bit         got_bits [$];
  logic [7:0] got_rb [$];
  int   ce_n, hs_n, rdy_n, done_n, nn_bad;
  int   first_ce, last_ce, done_cyc;
  logic nn_at_done, nn_after;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  // Drive one frame from tx[0:n-1]; record what the DUT did.
  task automatic run_frame(input int n, input int gap_after,
                           input int gap_len, input bit restart,
                           input int abort_bits, input int budget);
    int  idx, stall;
    bit  take;
    got_bits.delete();
    got_rb.delete();
    ce_n = 0; hs_n = 0; rdy_n = 0; done_n = 0; nn_bad = 0;
    first_ce = -1; last_ce = -1; done_cyc = -10;
    nn_at_done = 1'b0; nn_after = 1'b1;
    idx = 0; stall = 0;
    @(posedge clk); #1;
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      in_valid = (idx < n) && (stall == 0);
      in_data  = (idx < n) ? tx[idx] : 8'h00;
      start    = restart && (cyc == 4);
      @(negedge clk);
      if (m_conf_en) begin
        got_bits.push_back(m_bs_in);
        if (first_ce < 0) first_ce = cyc;
        last_ce = cyc;
        ce_n++;
      end
      if (m_rb_valid) got_rb.push_back(m_rb_data);
      if (m_in_ready) rdy_n++;
      if (m_busy && !m_nn_reset) nn_bad++;
      if (m_conf_en && !m_nn_reset) nn_bad++;
      if (m_done) begin
        done_n++;
        done_cyc = cyc;
        nn_at_done = m_nn_reset;
      end
      if (done_n > 0 && cyc == done_cyc + 1) nn_after = m_nn_reset;
      take = in_valid && m_in_ready;
      if (take) hs_n++;
      if (!take && stall > 0 && m_in_ready) stall--;
      @(posedge clk); #1;
      if (take) begin
        idx++;
        if (idx == gap_after) stall = gap_len;
      end
      if (abort_bits > 0 && ce_n >= abort_bits) break;
      if (done_n > 0 && cyc >= done_cyc + 1) break;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Compare the recorded frame with the expected serial content.
  task automatic check_frame(input int L, input int n, input int gap);
    int nb, mism, k;
    logic [7:0] e;
    nb = (L + 7) / 8;
    chk("done_count", done_n, 1);
    chk("conf_en_cycles", ce_n, L);
    mism = 0;
    for (int i = 0; i < L; i++) begin
      if (i >= got_bits.size()) mism++;
      else if (got_bits[i] !== tx[i / 8][7 - (i % 8)]) mism++;
    end
    chk("bs_in_bits", mism, 0);
    chk("done_latency", done_cyc - last_ce, 1);
    chk("gap_cycles", last_ce - first_ce + 1 - ce_n, gap);
    chk("handshakes", hs_n, n);
    if (gap == 0) chk("in_ready_cycles", rdy_n, n);
    chk("rb_count", got_rb.size(), nb);
    mism = 0;
    for (int j = 0; j < nb; j++) begin
      for (int i = 0; i < 8; i++) begin
        k = 8 * j + i;
        e[7 - i] = (k < L) ? pre[L - 1 - k] : 1'b0;
      end
      if (j >= got_rb.size()) mism++;
      else if (got_rb[j] !== e) mism++;
    end
    chk("rb_bytes", mism, 0);
    chk("nn_reset_busy", nn_bad, 0);
    chk("nn_reset_at_done", nn_at_done, 1);
    chk("nn_reset_after", nn_after, 0);
  endtask

  task automatic rand_pre();
    for (int i = 0; i < 425; i++) pre[i] = 1'($urandom % 2);
  endtask

  initial begin
    int gap;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; sel = 1'b0;
    ld = 1'b0; in_data = 8'h00; pre = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_outs",
        {a_conf_en, a_bs_in, a_in_ready, a_nn_reset,
         a_busy, a_done, a_rb_valid, a_rb_data},
        {7'b0001000, 8'h00});
    chk("rst_b_outs",
        {b_conf_en, b_bs_in, b_in_ready, b_nn_reset,
         b_busy, b_done, b_rb_valid, b_rb_data},
        {7'b0001000, 8'h00});
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("nn_release", a_nn_reset, 0);

    // Basic frame with chain preload 1010110011.
    tx[0] = 8'hA5; tx[1] = 8'hC0;
    pre = '0; pre[9:0] = 10'b1010110011;
    run_frame(2, 0, 0, 1'b0, 0, 100);
    check_frame(10, 2, 0);
    chk("rb_last", a_rb_data, 8'hC0);

    // Host stall of 5 cycles between the bytes.
    run_frame(2, 1, 5, 1'b0, 0, 100);
    check_frame(10, 2, 5);

    // Start while busy is ignored.
    tx[0] = 8'h3C; tx[1] = 8'h40;
    run_frame(2, 0, 0, 1'b1, 0, 100);
    check_frame(10, 2, 0);

    // Reset mid-frame, then a fresh all-ones frame.
    tx[0] = 8'h96; tx[1] = 8'h80;
    run_frame(2, 0, 0, 1'b0, 4, 100);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs",
        {a_conf_en, a_bs_in, a_in_ready, a_nn_reset,
         a_busy, a_done, a_rb_valid, a_rb_data},
        {7'b0001000, 8'h00});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("nn_hold_pre_edge", a_nn_reset, 1);
    @(posedge clk); #1;
    chk("nn_release_mid", a_nn_reset, 0);
    chk("no_resume", a_busy, 0);
    tx[0] = 8'hFF; tx[1] = 8'hFF;
    rand_pre();
    run_frame(2, 0, 0, 1'b0, 0, 100);
    check_frame(10, 2, 0);

    // Random 10-bit frames with random stalls.
    for (int r = 0; r < 6; r++) begin
      tx[0] = 8'($urandom);
      tx[1] = 8'($urandom);
      rand_pre();
      gap = int'($urandom_range(0, 6));
      run_frame(2, 1, gap, 1'b0, 0, 200);
      check_frame(10, 2, gap);
    end

    // Default-length chain: 425 bits in 54 bytes.
    sel = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 54; i++) tx[i] = 8'($urandom);
      rand_pre();
      gap = (r == 0) ? 0 : 3;
      run_frame(54, 20, gap, 1'b0, 0, 1500);
      check_frame(425, 54, gap);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/conf_loader.md
CONF_LOADER -- requirements
Module: conf_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 425, giving the neuron configuration chain length in bits (25 neurons x 17 bits).
REQ-002 SHALL have parameter NBYTES, default ceil(CHAIN_LEN/8), giving the number of host bytes per frame; this value is derived, not overridden.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to begin a configuration frame.
REQ-006 SHALL have ports in_data (input, 8 bits), in_valid (input, 1 bit) and in_ready (output, 1 bit): the host byte stream, MSB first.
REQ-007 SHALL have ports conf_en (output, 1 bit) and bs_in (output, 1 bit): the serial configuration drive into the neuron array chain.
REQ-008 SHALL have port bs_out, input, 1 bit: the chain tail, used for readback.
REQ-009 SHALL have port nn_reset, output, 1 bit: holds the neuron array in reset.
REQ-010 SHALL have ports rb_data (output, 8 bits) and rb_valid (output, 1 bit): the readback byte stream, with no backpressure.
REQ-011 SHALL have ports busy (output, 1 bit) and done (output, 1 bit, single-cycle pulse).

Function
REQ-012 SHALL implement the states IDLE, SHIFT and FINISH.
REQ-013 SHALL go IDLE->SHIFT on start=1; start is ignored in SHIFT and FINISH.
REQ-014 SHALL load bit counter = CHAIN_LEN and byte counter = NBYTES on entry to SHIFT.
REQ-015 SHALL drive in_ready = 1 only in SHIFT, with byte counter > 0, and with the byte buffer holding 0 or 1 unshifted bits; a full frame therefore shifts with no bubbles when in_valid stays high.
REQ-016 SHALL load the buffer and decrement the byte counter on in_valid & in_ready.
REQ-017 SHALL, on each cycle in SHIFT where the buffer holds a bit and bit counter > 0, register conf_en = 1 and bs_in = the buffer MSB, shift the buffer left, and decrement the bit counter.
REQ-018 SHALL otherwise register conf_en = 0; bs_in is don't-care when conf_en = 0 and is driven 0.
REQ-019 SHALL, for the last byte, shift only its CHAIN_LEN mod 8 MSBs (all 8 if the remainder is 0) and discard the rest.
REQ-020 SHALL let a host stall (in_valid = 0) insert conf_en = 0 cycles; frame content is unaffected.
REQ-021 SHALL go SHIFT->FINISH when the bit counter reaches 0; conf_en of the last bit is visible in that same cycle.
REQ-022 SHALL spend exactly one cycle in FINISH, pulse done = 1, then return to IDLE.
REQ-023 SHALL drive nn_reset = 1 whenever state != IDLE, including stall cycles and the FINISH cycle; this prevents neuron integration while conf_en = 0 mid-frame.
REQ-024 SHALL drive nn_reset = 1 for one cycle after FINISH as well, to reset the membranes.
REQ-025 SHALL drive busy = 1 whenever state != IDLE.
REQ-026 SHALL, on every cycle the registered conf_en = 1, sample bs_out into the readback shift register, MSB first.
REQ-027 SHALL pulse rb_valid = 1 with the assembled byte on rb_data after each 8 samples.
REQ-028 SHALL emit the final partial byte at FINISH, left-aligned and zero-padded; rb_valid therefore pulses exactly NBYTES times per frame.
REQ-029 SHALL hold rb_data at its last value when rb_valid = 0.

Reset
REQ-030 SHALL, on rst_n low (asynchronous, including mid-frame), enter IDLE, clear all counters and buffers, and drive conf_en = 0, bs_in = 0, in_ready = 0, nn_reset = 1, busy = 0, done = 0, rb_valid = 0 and rb_data = 0.
REQ-031 SHALL release nn_reset on the first clk edge after rst_n deasserts.
REQ-032 SHALL discard a partial frame on reset; the next frame requires a new start.

Structure
REQ-033 SHALL place in the shared package: the state enum {IDLE, SHIFT, FINISH}, the NEURON_BITS = 17 constant, the NEURONS = 25 constant, and the default CHAIN_LEN.
REQ-034 SHALL use one sub-module, conf_rb_deser: an 8-bit serial-to-parallel readback assembler with flush input.
REQ-035 SHALL keep the counters and the transmit buffer in the top module.

Verification (CHAIN_LEN = 10 unless stated)
REQ-036 SHALL cover: start, bytes 0xA5 then 0xC0 with in_valid held -> conf_en high for 10 consecutive cycles, bs_in = 1,0,1,0,0,1,0,1,1,1, done one cycle later, in_ready asserted exactly twice.
REQ-037 SHALL cover: bs_out tied to a 10-stage delay of bs_in gated by conf_en, preloaded 1010110011 -> rb_data 0xAC then 0xC0, rb_valid pulsed twice.
REQ-038 SHALL cover: in_valid low for 5 cycles between the bytes -> 5 conf_en = 0 gap cycles, nn_reset = 1 throughout, bit sequence unchanged.
REQ-039 SHALL cover: rst_n pulsed low after bit 4 -> outputs at reset values immediately; a new start with 0xFF, 0xFF -> 10 ones.
REQ-040 SHALL cover: start asserted again while busy -> ignored, no extra in_ready.
REQ-041 SHALL cover: default CHAIN_LEN = 425, 54 bytes -> 425 conf_en cycles, only the MSB of byte 54 shifted, 54 rb_valid pulses.
